univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: hold, shift left, shift right, parallel load.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/univ_shift_reg_if.sv | 35 +++
 rtl/shift_bit_counter.sv | 42 ++++
 rtl/univ_shift_reg.sv | 68 ++++++
 tb/tb_univ_shift_reg.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode codes and width helper for univ_shift_reg
// Contents: MODE_* operation codes, clog2() used to size the shift counter.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Ceiling log2, usable in constant expressions for parameter sizing.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control/data bundle for univ_shift_reg
// Signals:
//   en, mode, rot, sdi_l, sdi_r, pdi   driven by the master (user logic)
//   pdo, sdo_l, sdo_r, shift_cnt,
//   word_done                          driven by the slave (shift register)
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  import shift_pkg::*;

  localparam int CNT_W = clog2(WIDTH) + 1;

  logic             en;
  logic [1:0]       mode;
  logic             rot;
  logic             sdi_l;
  logic             sdi_r;
  logic [WIDTH-1:0] pdi;
  logic [WIDTH-1:0] pdo;
  logic             sdo_l;
  logic             sdo_r;
  logic [CNT_W-1:0] shift_cnt;
  logic             word_done;

  modport master (
    output en, mode, rot, sdi_l, sdi_r, pdi,
    input  pdo, sdo_l, sdo_r, shift_cnt, word_done
  );

  modport slave (
    input  en, mode, rot, sdi_l, sdi_r, pdi,
    output pdo, sdo_l, sdo_r, shift_cnt, word_done
  );

endinterface

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - modulo-WIDTH shift counter with registered wrap pulse
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr         restart the count (parallel load)
//   inc         one shift happened this cycle
//   cnt         shifts since last clear/reset/wrap, 0..WIDTH-1
//   wrap        one-cycle pulse after the WIDTH-th shift
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      // wrap is a pulse: cleared every edge unless this shift completes a word
      wrap <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register: hold, shift left/right, rotate, load
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    univ_shift_reg_if.slave: controls and serial/parallel data in,
//          register contents, serial outs, shift count and word pulse out
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  univ_shift_reg_if.slave   bus
);

  localparam int CNT_W = clog2(WIDTH) + 1;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             shl_in;
  logic             shr_in;
  logic             do_shift;
  logic             do_load;

  // Rotate recirculates the bit falling off the opposite end.
  assign shl_in = bus.rot ? data_q[WIDTH-1] : bus.sdi_l;
  assign shr_in = bus.rot ? data_q[0]       : bus.sdi_r;

  always_comb begin
    data_d = data_q;
    case (bus.mode)
      MODE_HOLD: data_d = data_q;
      MODE_SHL:  data_d = {data_q[WIDTH-2:0], shl_in};
      MODE_SHR:  data_d = {shr_in, data_q[WIDTH-1:1]};
      MODE_LOAD: data_d = bus.pdi;
      default:   data_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (bus.en) begin
      data_q <= data_d;
    end
  end

  assign do_shift = bus.en && ((bus.mode == MODE_SHL) || (bus.mode == MODE_SHR));
  assign do_load  = bus.en && (bus.mode == MODE_LOAD);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (do_load),
    .inc   (do_shift),
    .cnt   (bus.shift_cnt),
    .wrap  (bus.word_done)
  );

  assign bus.pdo   = data_q;
  assign bus.sdo_l = data_q[WIDTH-1];
  assign bus.sdo_r = data_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH 8, 2, 64)
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8))  if8 ();
  univ_shift_reg_if #(.WIDTH(2))  if2 ();
  univ_shift_reg_if #(.WIDTH(64)) if64 ();

  univ_shift_reg #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
  univ_shift_reg #(.WIDTH(2))  u2  (.clk(clk), .reset(reset), .bus(if2));
  univ_shift_reg #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(if64));

  // Reference model: register value as a number, shift count as a running total.
  int          widths [3] = '{8, 2, 64};
  logic [63:0] m_val    [3];
  int          m_shifts [3];
  logic        m_done   [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe(input int d, output logic [63:0] pdo, output logic [63:0] cnt,
                         output logic done, output logic sl, output logic sr);
    case (d)
      0: begin pdo = 64'(if8.pdo);  cnt = 64'(if8.shift_cnt);  done = if8.word_done;  sl = if8.sdo_l;  sr = if8.sdo_r;  end
      1: begin pdo = 64'(if2.pdo);  cnt = 64'(if2.shift_cnt);  done = if2.word_done;  sl = if2.sdo_l;  sr = if2.sdo_r;  end
      default: begin pdo = if64.pdo; cnt = 64'(if64.shift_cnt); done = if64.word_done; sl = if64.sdo_l; sr = if64.sdo_r; end
    endcase
  endtask

  task automatic step(input logic rst, input logic en, input logic [1:0] mode, input logic rot,
                      input logic sl, input logic sr, input logic [63:0] pdi);
    logic [63:0] o_pdo;
    logic [63:0] o_cnt;
    logic        o_done;
    logic        o_sl;
    logic        o_sr;
    reset = rst;
    if8.en  = en;  if8.mode  = mode; if8.rot  = rot; if8.sdi_l  = sl; if8.sdi_r  = sr; if8.pdi  = pdi[7:0];
    if2.en  = en;  if2.mode  = mode; if2.rot  = rot; if2.sdi_l  = sl; if2.sdi_r  = sr; if2.pdi  = pdi[1:0];
    if64.en = en;  if64.mode = mode; if64.rot = rot; if64.sdi_l = sl; if64.sdi_r = sr; if64.pdi = pdi;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      int          w;
      logic [63:0] mask;
      logic [63:0] fill;
      w = widths[d];
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      m_done[d] = 1'b0;
      if (rst) begin
        m_val[d] = 64'd0;
        m_shifts[d] = 0;
      end else if (en) begin
        if (mode == 2'b11) begin
          m_val[d] = pdi & mask;
          m_shifts[d] = 0;
        end else if (mode == 2'b01) begin
          fill = rot ? ((m_val[d] >> (w - 1)) & 64'd1) : 64'(sl);
          m_val[d] = ((m_val[d] * 2) + fill) & mask;
          m_shifts[d]++;
          m_done[d] = (m_shifts[d] % w) == 0;
        end else if (mode == 2'b10) begin
          fill = rot ? (m_val[d] & 64'd1) : 64'(sr);
          m_val[d] = (m_val[d] / 2) + (fill << (w - 1));
          m_shifts[d]++;
          m_done[d] = (m_shifts[d] % w) == 0;
        end
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      observe(d, o_pdo, o_cnt, o_done, o_sl, o_sr);
      check($sformatf("w%0d pdo", widths[d]), o_pdo, m_val[d]);
      check($sformatf("w%0d cnt", widths[d]), o_cnt, 64'(m_shifts[d] % widths[d]));
      check($sformatf("w%0d word_done", widths[d]), 64'(o_done), 64'(m_done[d]));
      check($sformatf("w%0d sdo_l", widths[d]), 64'(o_sl), (m_val[d] >> (widths[d] - 1)) & 64'd1);
      check($sformatf("w%0d sdo_r", widths[d]), 64'(o_sr), m_val[d] & 64'd1);
    end
  endtask

  initial begin
    logic [7:0]  exp2 [8];
    logic        sdo2 [8];
    logic [7:0]  exp3 [8];
    logic [63:0] word;
    int          pulses;
    int          last_pulse;

    exp2 = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
    sdo2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp3 = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};

    // Reset dominates a pending LOAD of all ones.
    step(1, 1, 2'b11, 0, 0, 0, {64{1'b1}});
    step(1, 1, 2'b11, 0, 0, 0, {64{1'b1}});
    check("reset pdo", 64'(if8.pdo), 64'h0);
    check("reset cnt", 64'(if8.shift_cnt), 64'h0);

    // SHL with serial ones filling from bit 0.
    step(0, 1, 2'b11, 0, 0, 0, 64'hA5);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("shl sdo_l before %0d", i), 64'(if8.sdo_l), 64'(sdo2[i]));
      step(0, 1, 2'b01, 0, 1, 0, 64'h0);
      check($sformatf("shl pdo %0d", i), 64'(if8.pdo), 64'(exp2[i]));
      check($sformatf("shl word_done %0d", i), 64'(if8.word_done), (i == 7) ? 64'd1 : 64'd0);
    end

    // SHR rotate, then 16 continuous shifts giving two pulses 8 apart.
    step(0, 1, 2'b11, 0, 0, 0, 64'h81);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'b10, 1, 0, 0, 64'h0);
      check($sformatf("ror pdo %0d", i), 64'(if8.pdo), 64'(exp3[i]));
    end
    pulses = 0;
    last_pulse = -100;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 2'b10, 1, 0, 0, 64'h0);
      if (if8.word_done) begin
        if (pulses == 1) check("pulse spacing", 64'(i - last_pulse), 64'd8);
        pulses++;
        last_pulse = i;
      end
    end
    check("pulses in 16", 64'(pulses), 64'd2);

    // Enable-low and HOLD freeze data and count; direction change keeps counting.
    step(0, 1, 2'b11, 0, 0, 0, 64'h01);
    repeat (3) step(0, 1, 2'b01, 0, 0, 0, 64'h0);
    check("shl3 pdo", 64'(if8.pdo), 64'h08);
    check("shl3 cnt", 64'(if8.shift_cnt), 64'd3);
    repeat (2) step(0, 0, 2'b01, 0, 1, 1, 64'hFF);
    step(0, 1, 2'b00, 0, 1, 1, 64'hFF);
    check("held cnt", 64'(if8.shift_cnt), 64'd3);
    repeat (4) step(0, 1, 2'b10, 0, 0, 0, 64'h0);
    check("pre-wrap done", 64'(if8.word_done), 64'd0);
    step(0, 1, 2'b10, 0, 0, 0, 64'h0);
    check("mixed wrap done", 64'(if8.word_done), 64'd1);
    check("mixed wrap pdo", 64'(if8.pdo), 64'h00);

    // LOAD mid-word restarts the count; reset mid-word discards it.
    step(0, 1, 2'b11, 0, 0, 0, 64'h3C);
    repeat (5) step(0, 1, 2'b01, 0, 1, 0, 64'h0);
    step(0, 1, 2'b11, 0, 0, 0, 64'hF0);
    check("reload cnt", 64'(if8.shift_cnt), 64'd0);
    check("reload done", 64'(if8.word_done), 64'd0);
    pulses = 0;
    repeat (8) begin
      step(0, 1, 2'b01, 0, 0, 0, 64'h0);
      if (if8.word_done) pulses++;
    end
    check("reload word pulses", 64'(pulses), 64'd1);
    repeat (6) step(0, 1, 2'b10, 0, 1, 1, 64'h0);
    check("cnt before reset", 64'(if8.shift_cnt), 64'd6);
    step(1, 1, 2'b10, 0, 1, 1, 64'h0);
    check("cnt after reset", 64'(if8.shift_cnt), 64'd0);
    pulses = 0;
    repeat (7) begin
      step(0, 1, 2'b10, 0, 1, 1, 64'h0);
      if (if8.word_done) pulses++;
    end
    check("no early pulse", 64'(pulses), 64'd0);
    step(0, 1, 2'b10, 0, 1, 1, 64'h0);
    check("full word pulse", 64'(if8.word_done), 64'd1);

    // Full-width rotate returns the loaded word at both width extremes.
    word = {$urandom, $urandom};
    step(0, 1, 2'b11, 0, 0, 0, word);
    repeat (64) step(0, 1, 2'b01, 1, 0, 0, 64'h0);
    check("w64 rotate home", if64.pdo, word);
    check("w64 rotate done", 64'(if64.word_done), 64'd1);
    check("w2 rotate home", 64'(if2.pdo), 64'(word[1:0]));
    check("w2 rotate done", 64'(if2.word_done), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85), 2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
